// File: rtl/softusb_rxfront.sv
// USB receive front end: DPLL bit recovery, NRZI decode, SYNC detect, bit unstuffing,
// LSB-first byte assembly and EOP/error reporting for one full- or low-speed port.
module softusb_rxfront #(
    parameter int FS_DIV   = 4,
    parameter int LS_DIV   = 32,
    parameter int SYNC_MIN = 5
) (
    input  logic       usb_clk,
    input  logic       usb_rst_n,
    input  logic       rx_en,
    input  logic       low_speed,
    input  logic       rcv,
    input  logic       vp,
    input  logic       vm,
    output logic [7:0] rx_data,
    output logic       rx_strobe,
    output logic       rx_active,
    output logic       rx_error,
    output logic       rx_eop
);

    localparam int PH_W = $clog2(LS_DIV > FS_DIV ? LS_DIV : FS_DIV);

    localparam logic [PH_W-1:0] FS_LAST = PH_W'(FS_DIV - 1);
    localparam logic [PH_W-1:0] LS_LAST = PH_W'(LS_DIV - 1);
    localparam logic [PH_W-1:0] FS_MID  = PH_W'(FS_DIV / 2);
    localparam logic [PH_W-1:0] LS_MID  = PH_W'(LS_DIV / 2);

    // Registered line state: bit 1 flags SE0, bit 0 is 1 for J.
    localparam logic [1:0] LN_K   = 2'b00;
    localparam logic [1:0] LN_SE0 = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP,
        S_ABORT,
        S_ABORT_J
    } state_t;

    state_t          state_q,  state_d;
    logic            ls_q,     ls_d;
    logic [1:0]      line_q,   line_d;
    logic [PH_W-1:0] ph_q,     ph_d;
    logic            prev_j_q, prev_j_d;
    logic [2:0]      zeros_q,  zeros_d;
    logic [2:0]      ones_q,   ones_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q,  shift_d;
    logic [7:0]      data_q,   data_d;
    logic            strobe_q, strobe_d;
    logic            active_q, active_d;
    logic            error_q,  error_d;
    logic            eop_q,    eop_d;

    logic [PH_W-1:0] ph_last;
    logic [PH_W-1:0] ph_mid;
    logic [1:0]      line_in;
    logic            sample;
    logic            samp_se0;
    logic            samp_j;
    logic            dec_bit;

    // Line decode, DPLL phase and NRZI reference
    always_comb begin
        ph_last  = ls_q ? LS_LAST : FS_LAST;
        ph_mid   = ls_q ? LS_MID  : FS_MID;
        line_in  = (!vp && !vm) ? LN_SE0 : {1'b0, rcv ^ ls_q};
        line_d   = line_in;
        ls_d     = (state_q == S_IDLE) ? low_speed : ls_q;

        // ph is 0 in the first cycle the registered line shows a new state.
        if (line_in != line_q) begin
            ph_d = '0;
        end else if (ph_q >= ph_last) begin
            ph_d = '0;
        end else begin
            ph_d = ph_q + PH_W'(1);
        end

        sample   = (ph_q == ph_mid);
        samp_se0 = (line_q == LN_SE0);
        samp_j   = line_q[0];
        dec_bit  = (samp_j == prev_j_q);
        prev_j_d = (sample && !samp_se0) ? samp_j : prev_j_q;
    end

    // Packet FSM
    always_comb begin
        state_d  = state_q;
        zeros_d  = zeros_q;
        ones_d   = ones_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        error_d  = 1'b0;
        eop_d    = 1'b0;
        active_d = active_q;

        case (state_q)
            S_IDLE: begin
                active_d = 1'b0;
                if (sample && !samp_se0 && !samp_j) begin
                    state_d = S_SYNC;
                    zeros_d = 3'd1;
                end
            end

            S_SYNC: begin
                if (sample) begin
                    if (samp_se0) begin
                        state_d = S_IDLE;
                    end else if (!dec_bit) begin
                        zeros_d = (zeros_q == 3'd7) ? 3'd7 : zeros_q + 3'd1;
                    end else if (zeros_q >= 3'(SYNC_MIN)) begin
                        state_d  = S_DATA;
                        active_d = 1'b1;
                        ones_d   = 3'd0;
                        bitcnt_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (sample) begin
                    // SE0 wins over the stuff check, even in the 7th-one position.
                    if (samp_se0) begin
                        state_d = S_EOP;
                        error_d = (bitcnt_q != 3'd0);
                    end else if (ones_q == 3'd6) begin
                        if (dec_bit) begin
                            error_d  = 1'b1;
                            active_d = 1'b0;
                            state_d  = S_ABORT;
                        end else begin
                            ones_d = 3'd0;
                        end
                    end else begin
                        shift_d  = {dec_bit, shift_q[7:1]};
                        ones_d   = dec_bit ? ones_q + 3'd1 : 3'd0;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            data_d   = {dec_bit, shift_q[7:1]};
                            strobe_d = 1'b1;
                        end
                    end
                end
            end

            S_EOP: begin
                if (sample && !samp_se0) begin
                    active_d = 1'b0;
                    eop_d    = samp_j;
                    state_d  = S_IDLE;
                end
            end

            S_ABORT: begin
                active_d = 1'b0;
                if (sample && samp_se0) begin
                    state_d = S_ABORT_J;
                end
            end

            S_ABORT_J: begin
                active_d = 1'b0;
                if (sample && !samp_se0 && samp_j) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d  = S_IDLE;
                active_d = 1'b0;
            end
        endcase

        if (!rx_en) begin
            state_d  = S_IDLE;
            active_d = 1'b0;
            strobe_d = 1'b0;
            error_d  = 1'b0;
            eop_d    = 1'b0;
        end
    end

    always_ff @(posedge usb_clk) begin
        if (!usb_rst_n) begin
            state_q  <= S_IDLE;
            ls_q     <= 1'b0;
            line_q   <= LN_K;
            ph_q     <= '0;
            prev_j_q <= 1'b0;
            zeros_q  <= 3'd0;
            ones_q   <= 3'd0;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'h00;
            data_q   <= 8'h00;
            strobe_q <= 1'b0;
            active_q <= 1'b0;
            error_q  <= 1'b0;
            eop_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ls_q     <= ls_d;
            line_q   <= line_d;
            ph_q     <= ph_d;
            prev_j_q <= prev_j_d;
            zeros_q  <= zeros_d;
            ones_q   <= ones_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            active_q <= active_d;
            error_q  <= error_d;
            eop_q    <= eop_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_strobe = strobe_q;
    assign rx_active = active_q;
    assign rx_error  = error_q;
    assign rx_eop    = eop_q;

endmodule

// File: tb/tb_softusb_rxfront.sv
// Bench for softusb_rxfront: packet-level stimulus (stuffing + NRZI line encoder) compared
// against expected bytes/errors/EOPs derived directly from each packet description.
module tb_softusb_rxfront;

    logic       usb_clk   = 1'b0;
    logic       usb_rst_n = 1'b0;
    logic       rx_en     = 1'b1;
    logic       low_speed = 1'b0;
    logic       rcv       = 1'b1;
    logic       vp        = 1'b1;
    logic       vm        = 1'b0;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic       rx_active;
    logic       rx_error;
    logic       rx_eop;

    softusb_rxfront dut (
        .usb_clk   (usb_clk),
        .usb_rst_n (usb_rst_n),
        .rx_en     (rx_en),
        .low_speed (low_speed),
        .rcv       (rcv),
        .vp        (vp),
        .vm        (vm),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .rx_active (rx_active),
        .rx_error  (rx_error),
        .rx_eop    (rx_eop)
    );

    always #5 usb_clk = ~usb_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state, cleared at the start of every packet
    logic [7:0] got_q[$];
    int         mon_err;
    int         mon_eop;
    int         mon_both;
    bit         saw_active;

    // Stimulus state
    bit         bits_q[$];
    int         ones_run;
    bit         cur_ls;
    logic [7:0] exp_q[$];

    typedef struct {
        string      name;
        int         nbytes;
        logic [7:0] b [3];
        int         extra;
        logic [7:0] extra_v;
        bit         ls;
        bit         jit;
        bit         en;
        int         exp_err;
        int         exp_eop;
    } vec_t;

    vec_t vecs[8];

    always @(negedge usb_clk) begin
        if (rx_strobe) got_q.push_back(rx_data);
        if (rx_error) mon_err++;
        if (rx_eop) mon_eop++;
        if (rx_strobe && rx_error) mon_both++;
        if (rx_active) saw_active = 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // lvl: 0 = K, 1 = J, 2 = SE0
    task automatic set_line(input int lvl);
        logic dp;
        if (lvl == 2) begin
            vp  = 1'b0;
            vm  = 1'b0;
            rcv = 1'b0;
        end else begin
            dp  = (lvl == 1) ^ cur_ls;
            vp  = dp;
            vm  = !dp;
            rcv = dp;
        end
    endtask

    task automatic hold(input int lvl, input int n);
        set_line(lvl);
        repeat (n) @(negedge usb_clk);
    endtask

    task automatic push_bits(input logic [7:0] v, input int n, input bit stuff);
        for (int i = 0; i < n; i++) begin
            bits_q.push_back(v[i]);
            ones_run = v[i] ? ones_run + 1 : 0;
            if (stuff && ones_run == 6) begin
                bits_q.push_back(1'b0);
                ones_run = 0;
            end
        end
    endtask

    task automatic start_pkt(input logic [7:0] sync_v, input int sync_n);
        got_q.delete();
        exp_q.delete();
        mon_err    = 0;
        mon_eop    = 0;
        mon_both   = 0;
        saw_active = 1'b0;
        bits_q.delete();
        ones_run = 0;
        push_bits(sync_v, sync_n, 1'b0);
        ones_run = 0;
    endtask

    task automatic set_speed(input bit ls);
        cur_ls    = ls;
        low_speed = ls;
    endtask

    // Idle J, NRZI-encoded bits, SE0 for two bit times, end_lvl for one bit, then idle J.
    task automatic transmit(input bit jit, input int end_lvl);
        int div;
        int lvl;
        div = cur_ls ? 32 : 4;
        lvl = 1;
        hold(1, 4 * div);
        for (int i = 0; i < bits_q.size(); i++) begin
            if (!bits_q[i]) lvl = 1 - lvl;
            hold(lvl, (jit && !cur_ls) ? ((i % 2 == 1) ? 5 : 3) : div);
        end
        hold(2, 2 * div);
        hold(end_lvl, div);
        hold(1, 6 * div);
    endtask

    task automatic check_pkt(input string name, input int exp_err, input int exp_eop, input bit exp_act);
        int n;
        check({name, ".nstrobe"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.byte%0d", name, i), int'(got_q[i]), int'(exp_q[i]));
        end
        check({name, ".error"}, mon_err, exp_err);
        check({name, ".eop"}, mon_eop, exp_eop);
        check({name, ".active_seen"}, int'(saw_active), int'(exp_act));
        check({name, ".active_end"}, int'(rx_active), 0);
        check({name, ".strobe_and_error"}, mon_both, 0);
        $display("pkt %-14s strobes=%0d errors=%0d eops=%0d", name, got_q.size(), mon_err, mon_eop);
    endtask

    function automatic vec_t mk(input string nm, input int nb, input logic [7:0] b0,
                                input logic [7:0] b1, input logic [7:0] b2, input int ex,
                                input logic [7:0] exv, input bit ls, input bit jit, input bit en,
                                input int err, input int eop);
        vec_t v;
        v.name    = nm;
        v.nbytes  = nb;
        v.b[0]    = b0;
        v.b[1]    = b1;
        v.b[2]    = b2;
        v.extra   = ex;
        v.extra_v = exv;
        v.ls      = ls;
        v.jit     = jit;
        v.en      = en;
        v.exp_err = err;
        v.exp_eop = eop;
        return v;
    endfunction

    initial begin
        int nb;
        int extra;
        bit jit;
        logic [7:0] rb [3];
        logic [7:0] exv;

        vecs[0] = mk("fs_a5c3",    2, 8'hA5, 8'hC3, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1);
        vecs[1] = mk("fs_stuff",   2, 8'hFF, 8'h01, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1);
        vecs[2] = mk("ls_5a",      1, 8'h5A, 8'h00, 8'h00, 0, 8'h00, 1, 0, 1, 0, 1);
        vecs[3] = mk("fs_jitter",  1, 8'hA5, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1, 0, 1);
        vecs[4] = mk("fs_eop_mid", 1, 8'h2D, 8'h00, 8'h00, 3, 8'h05, 0, 0, 1, 1, 1);
        vecs[5] = mk("fs_007e",    2, 8'h00, 8'h7E, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1);
        vecs[6] = mk("fs_disabled",1, 8'hA5, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0);
        vecs[7] = mk("ls_eop_mid", 1, 8'h3C, 8'h00, 8'h00, 5, 8'h15, 1, 0, 1, 1, 1);

        // Reset state
        set_speed(1'b0);
        set_line(1);
        repeat (4) @(negedge usb_clk);
        check("reset.rx_data", int'(rx_data), 0);
        check("reset.rx_strobe", int'(rx_strobe), 0);
        check("reset.rx_active", int'(rx_active), 0);
        check("reset.rx_error", int'(rx_error), 0);
        check("reset.rx_eop", int'(rx_eop), 0);
        usb_rst_n = 1'b1;
        hold(1, 16);

        // Table-driven packets
        for (int v = 0; v < 8; v++) begin
            set_speed(vecs[v].ls);
            rx_en = vecs[v].en;
            start_pkt(8'h80, 8);
            for (int k = 0; k < vecs[v].nbytes; k++) push_bits(vecs[v].b[k], 8, 1'b1);
            if (vecs[v].extra != 0) push_bits(vecs[v].extra_v, vecs[v].extra, 1'b1);
            transmit(vecs[v].jit, 1);
            rx_en = 1'b1;
            if (vecs[v].en) begin
                for (int k = 0; k < vecs[v].nbytes; k++) exp_q.push_back(vecs[v].b[k]);
            end
            check_pkt(vecs[v].name, vecs[v].exp_err, vecs[v].exp_eop, vecs[v].en);
        end
        set_speed(1'b0);

        // Seven decoded ones with no stuff bit
        start_pkt(8'h80, 8);
        push_bits(8'h7F, 7, 1'b0);
        push_bits(8'h00, 3, 1'b0);
        transmit(1'b0, 1);
        check_pkt("fs_stuff_err", 1, 0, 1'b1);

        // SE0 arriving right after six ones at a byte boundary
        start_pkt(8'h80, 8);
        push_bits(8'hFC, 8, 1'b0);
        transmit(1'b0, 1);
        exp_q.push_back(8'hFC);
        check_pkt("fs_se0_7th", 0, 1, 1'b1);

        // SE0 followed by K: packet closes without rx_eop
        start_pkt(8'h80, 8);
        push_bits(8'h96, 8, 1'b1);
        transmit(1'b0, 0);
        exp_q.push_back(8'h96);
        check_pkt("fs_eop_k", 0, 0, 1'b1);

        // SYNC with exactly SYNC_MIN zeros is accepted
        start_pkt(8'h20, 6);
        push_bits(8'h99, 8, 1'b1);
        transmit(1'b0, 1);
        exp_q.push_back(8'h99);
        check_pkt("fs_sync_min", 0, 1, 1'b1);

        // SYNC with one zero too few is rejected silently
        start_pkt(8'h10, 5);
        push_bits(8'h07, 3, 1'b0);
        transmit(1'b0, 1);
        check_pkt("fs_sync_short", 0, 0, 1'b0);

        // Reset pulse inside the first data byte of a packet
        start_pkt(8'h80, 8);
        push_bits(8'hF0, 8, 1'b1);
        fork
            transmit(1'b0, 1);
            begin
                repeat ((4 + 8 + 3) * 4 + 2) @(negedge usb_clk);
                usb_rst_n = 1'b0;
                @(negedge usb_clk);
                usb_rst_n = 1'b1;
                check("rst_mid.rx_data", int'(rx_data), 0);
                check("rst_mid.rx_active", int'(rx_active), 0);
                check("rst_mid.rx_strobe", int'(rx_strobe), 0);
            end
        join
        check("rst_mid.nstrobe", got_q.size(), 0);
        check("rst_mid.eop", mon_eop, 0);
        check("rst_mid.error", mon_err, 0);
        $display("pkt %-14s strobes=%0d errors=%0d eops=%0d", "rst_mid", got_q.size(), mon_err, mon_eop);

        start_pkt(8'h80, 8);
        push_bits(8'h3C, 8, 1'b1);
        transmit(1'b0, 1);
        exp_q.push_back(8'h3C);
        check_pkt("fs_after_rst", 0, 1, 1'b1);

        // Randomized packets: every whole byte strobed, error iff the packet ends mid-byte
        for (int r = 0; r < 10; r++) begin
            nb    = $urandom_range(1, 3);
            extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            exv   = 8'($urandom);
            jit   = 1'($urandom_range(0, 1));
            set_speed($urandom_range(0, 3) == 0);
            for (int k = 0; k < 3; k++) rb[k] = 8'($urandom);
            start_pkt(8'h80, 8);
            for (int k = 0; k < nb; k++) push_bits(rb[k], 8, 1'b1);
            if (extra != 0) push_bits(exv, extra, 1'b1);
            transmit(jit, 1);
            for (int k = 0; k < nb; k++) exp_q.push_back(rb[k]);
            check_pkt($sformatf("rand%0d", r), (extra != 0) ? 1 : 0, 1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
